// File: rtl/actor_responder_if.sv
// Actor handshake, FIFO and status signals for actor_responder.
// Ports (slave = actor side):
//   ap_start, guard_en, in_empty_n, in_dout, out_full_n     -> into the actor
//   ap_done, ap_idle, ap_ready, ap_return, in_read,
//   out_write, out_din, firings_total                        -> out of the actor
interface actor_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ap_start;
  logic                  ap_done;
  logic                  ap_idle;
  logic                  ap_ready;
  logic [31:0]           ap_return;
  logic                  guard_en;
  logic                  in_empty_n;
  logic                  in_read;
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  out_full_n;
  logic                  out_write;
  logic [DATA_WIDTH-1:0] out_din;
  logic [31:0]           firings_total;

  modport slave (
    input  ap_start, guard_en, in_empty_n, in_dout, out_full_n,
    output ap_done, ap_idle, ap_ready, ap_return, in_read,
           out_write, out_din, firings_total
  );

  modport master (
    output ap_start, guard_en, in_empty_n, in_dout, out_full_n,
    input  ap_done, ap_idle, ap_ready, ap_return, in_read,
           out_write, out_din, firings_total
  );
endinterface

// File: rtl/actor_responder.sv
// Dataflow actor: per invocation, repeatedly consumes one token from a FWFT
// input FIFO, computes token+INCREMENT over COMPUTE_LATENCY cycles and writes
// it to the output FIFO, until blocked or MAX_FIRINGS is reached.
// Ports:
//   ap_clk  - clock, rising edge
//   ap_rst  - synchronous active-high reset
//   bus     - actor_responder_if.slave (ap_* handshake, guard, FIFO ports, counters)
module actor_responder #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int          INCREMENT       = 1,
  parameter int unsigned COMPUTE_LATENCY = 1,
  parameter int unsigned MAX_FIRINGS     = 4
) (
  input logic           ap_clk,
  input logic           ap_rst,
  actor_responder_if.slave bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned LAT_W = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [31:0] RET_IDLE        = 32'd0;
  localparam logic [31:0] RET_WAIT_INPUT  = 32'd2;
  localparam logic [31:0] RET_WAIT_OUTPUT = 32'd3;
  localparam logic [31:0] RET_WAIT_GAURD  = 32'd4;
  localparam logic [31:0] RET_EXECUTED    = 32'd5;

  logic [2:0]            r_state;
  logic [2:0]            w_next_state;
  logic [CNT_W-1:0]      r_count;
  logic [LAT_W-1:0]      r_lat;
  logic [DATA_WIDTH-1:0] r_out_din;
  logic [31:0]           r_total;
  logic [31:0]           r_return;
  logic                  w_in_read;
  logic                  w_out_write;
  logic [31:0]           w_reason;

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state, FIFO strobes and block reason
  always_comb begin
    w_next_state = r_state;
    w_in_read    = 1'b0;
    w_out_write  = 1'b0;
    w_reason     = RET_IDLE;
    case (r_state)
      S_IDLE: begin
        if (bus.ap_start) w_next_state = S_CHECK;
      end
      S_CHECK: begin
        if (r_count == CNT_W'(MAX_FIRINGS)) begin
          w_next_state = S_DONE;
        end else if (!bus.guard_en) begin
          w_reason     = RET_WAIT_GAURD;
          w_next_state = S_DONE;
        end else if (!bus.in_empty_n) begin
          w_reason     = RET_WAIT_INPUT;
          w_next_state = S_DONE;
        end else if (!bus.out_full_n) begin
          w_reason     = RET_WAIT_OUTPUT;
          w_next_state = S_DONE;
        end else begin
          w_in_read    = 1'b1;
          w_next_state = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (r_lat == '0) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        w_out_write = bus.out_full_n;
        if (bus.out_full_n) w_next_state = S_CHECK;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: firing counters, result latch and return code
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_count   <= '0;
      r_lat     <= '0;
      r_out_din <= '0;
      r_total   <= '0;
      r_return  <= RET_IDLE;
    end else begin
      if (r_state == S_IDLE && bus.ap_start) r_count <= '0;
      // The result is formed at read time so out_din is stable through COMPUTE/WRITE
      if (w_in_read) begin
        r_out_din <= DATA_WIDTH'(bus.in_dout + DATA_WIDTH'(INCREMENT));
        r_lat     <= LAT_W'(COMPUTE_LATENCY - 1);
      end
      if (r_state == S_COMPUTE && r_lat != '0) r_lat <= r_lat - LAT_W'(1);
      if (w_out_write) begin
        r_count <= r_count + CNT_W'(1);
        r_total <= r_total + 32'd1;
      end
      // Registered on entry to DONE so it is visible during the DONE cycle
      if (r_state == S_CHECK && w_next_state == S_DONE)
        r_return <= (r_count != '0) ? RET_EXECUTED : w_reason;
    end
  end

  assign bus.ap_idle       = (r_state == S_IDLE);
  assign bus.ap_done       = (r_state == S_DONE);
  assign bus.ap_ready      = (r_state == S_DONE);
  assign bus.ap_return     = r_return;
  assign bus.in_read       = w_in_read;
  assign bus.out_write     = w_out_write;
  assign bus.out_din       = r_out_din;
  assign bus.firings_total = r_total;

endmodule

// File: tb/tb_actor_responder.sv
// Directed bench for actor_responder (DATA_WIDTH=32, INCREMENT=1,
// COMPUTE_LATENCY=1, MAX_FIRINGS=4) with a behavioural FWFT input FIFO and
// an output write log.
module tb_actor_responder;

  logic ap_clk;
  logic ap_rst;

  actor_responder_if #(.DATA_WIDTH(32)) bus ();

  actor_responder #(
    .DATA_WIDTH(32), .INCREMENT(1), .COMPUTE_LATENCY(1), .MAX_FIRINGS(4)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bus)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Input FIFO model
  logic [31:0] fifo_mem [0:15];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  assign bus.in_empty_n = (rd_ptr != wr_ptr);
  assign bus.in_dout    = fifo_mem[rd_ptr[3:0]];
  always @(posedge ap_clk) if (bus.in_read && bus.in_empty_n) rd_ptr <= rd_ptr + 8'd1;

  // Output write log
  logic [31:0] out_log [0:31];
  logic [7:0]  out_cnt = 8'd0;
  always @(posedge ap_clk) begin
    if (bus.out_write) begin
      out_log[out_cnt[4:0]] <= bus.out_din;
      out_cnt <= out_cnt + 8'd1;
    end
  end

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    fifo_mem[wr_ptr[3:0]] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // Pulse ap_start from an IDLE cycle and wait (bounded) for ap_done.
  // Optionally holds out_full_n low for stall_len cycles from cycle stall_at.
  task automatic run_call(input int stall_at, input int stall_len,
                          output int lat, output int stall_writes);
    lat = 0;
    stall_writes = 0;
    bus.ap_start = 1'b1;
    while (lat < 200) begin
      tick();
      lat++;
      bus.ap_start = 1'b0;
      bus.out_full_n = !(stall_len > 0 && lat >= stall_at && lat < stall_at + stall_len);
      #1;
      if (!bus.out_full_n && bus.out_write) stall_writes++;
      if (bus.ap_done) break;
    end
  endtask

  task automatic test_reset;
    ap_rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({bus.ap_idle, bus.ap_done, bus.ap_ready, bus.in_read, bus.out_write} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 10000",
               {bus.ap_idle, bus.ap_done, bus.ap_ready, bus.in_read, bus.out_write});
    end
    n_checks++;
    if (bus.ap_return !== 32'd0) begin n_fail++; $display("FAIL reset_return: got %0d expected 0", bus.ap_return); end
    n_checks++;
    if (bus.out_din !== 32'd0) begin n_fail++; $display("FAIL reset_out_din: got %0h expected 0", bus.out_din); end
    n_checks++;
    if (bus.firings_total !== 32'd0) begin n_fail++; $display("FAIL reset_total: got %0d expected 0", bus.firings_total); end
    ap_rst = 1'b0;
    tick();
  endtask

  task automatic test_empty_input;
    int lat, sw;
    logic [7:0] rd0;
    bus.guard_en = 1'b1;
    rd0 = rd_ptr;
    run_call(0, 0, lat, sw);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL empty_latency: got %0d expected 2", lat); end
    n_checks++;
    if (bus.ap_return !== 32'd2) begin n_fail++; $display("FAIL empty_return: got %0d expected 2", bus.ap_return); end
    n_checks++;
    if (bus.ap_ready !== 1'b1 || bus.ap_idle !== 1'b0) begin
      n_fail++; $display("FAIL empty_ready_idle: got ready=%b idle=%b expected ready=1 idle=0", bus.ap_ready, bus.ap_idle);
    end
    n_checks++;
    if (rd_ptr !== rd0) begin n_fail++; $display("FAIL empty_no_read: got %0d reads expected 0", rd_ptr - rd0); end
    tick();
    n_checks++;
    if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0) begin
      n_fail++; $display("FAIL empty_back_idle: got idle=%b done=%b expected idle=1 done=0", bus.ap_idle, bus.ap_done);
    end
  endtask

  task automatic test_guard_block;
    int lat, sw;
    logic [7:0] rd0;
    push(32'd10); push(32'd20); push(32'hFFFF_FFFF);
    bus.guard_en = 1'b0;
    rd0 = rd_ptr;
    run_call(0, 0, lat, sw);
    n_checks++;
    if (bus.ap_return !== 32'd4) begin n_fail++; $display("FAIL guard_return: got %0d expected 4", bus.ap_return); end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL guard_latency: got %0d expected 2", lat); end
    n_checks++;
    if (rd_ptr !== rd0) begin n_fail++; $display("FAIL guard_no_read: got %0d reads expected 0", rd_ptr - rd0); end
    n_checks++;
    if (bus.firings_total !== 32'd0) begin n_fail++; $display("FAIL guard_total: got %0d expected 0", bus.firings_total); end
    tick();
  endtask

  task automatic test_three_tokens;
    int lat, sw;
    logic [7:0] o0;
    bus.guard_en = 1'b1;
    o0 = out_cnt;
    run_call(0, 0, lat, sw);
    n_checks++;
    if (lat !== 11) begin n_fail++; $display("FAIL three_latency: got %0d expected 11", lat); end
    n_checks++;
    if (bus.ap_return !== 32'd5) begin n_fail++; $display("FAIL three_return: got %0d expected 5", bus.ap_return); end
    n_checks++;
    if (bus.firings_total !== 32'd3) begin n_fail++; $display("FAIL three_total: got %0d expected 3", bus.firings_total); end
    n_checks++;
    if (out_cnt - o0 !== 8'd3) begin n_fail++; $display("FAIL three_writes: got %0d expected 3", out_cnt - o0); end
    n_checks++;
    if (out_log[o0[4:0]] !== 32'd11) begin n_fail++; $display("FAIL three_out0: got %0d expected 11", out_log[o0[4:0]]); end
    n_checks++;
    if (out_log[5'(o0 + 8'd1)] !== 32'd21) begin n_fail++; $display("FAIL three_out1: got %0d expected 21", out_log[5'(o0 + 8'd1)]); end
    n_checks++;
    if (out_log[5'(o0 + 8'd2)] !== 32'd0) begin n_fail++; $display("FAIL three_out2_wrap: got %0h expected 0", out_log[5'(o0 + 8'd2)]); end
    tick(); tick();
    n_checks++;
    if (bus.ap_return !== 32'd5) begin n_fail++; $display("FAIL three_return_hold: got %0d expected 5", bus.ap_return); end
  endtask

  task automatic test_max_firings;
    int lat, sw;
    logic [7:0] o0;
    for (int k = 0; k < 6; k++) push(32'(100 + k));
    o0 = out_cnt;
    run_call(0, 0, lat, sw);
    n_checks++;
    if (lat !== 14) begin n_fail++; $display("FAIL max_latency: got %0d expected 14", lat); end
    n_checks++;
    if (out_cnt - o0 !== 8'd4) begin n_fail++; $display("FAIL max_writes: got %0d expected 4", out_cnt - o0); end
    n_checks++;
    if (bus.ap_return !== 32'd5) begin n_fail++; $display("FAIL max_return: got %0d expected 5", bus.ap_return); end
    n_checks++;
    if (wr_ptr - rd_ptr !== 8'd2) begin n_fail++; $display("FAIL max_remaining: got %0d expected 2", wr_ptr - rd_ptr); end
    n_checks++;
    if (out_log[5'(o0 + 8'd3)] !== 32'd104) begin n_fail++; $display("FAIL max_last_out: got %0d expected 104", out_log[5'(o0 + 8'd3)]); end
    tick();
    o0 = out_cnt;
    run_call(0, 0, lat, sw);
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL max2_latency: got %0d expected 8", lat); end
    n_checks++;
    if (out_cnt - o0 !== 8'd2) begin n_fail++; $display("FAIL max2_writes: got %0d expected 2", out_cnt - o0); end
    n_checks++;
    if (bus.ap_return !== 32'd5) begin n_fail++; $display("FAIL max2_return: got %0d expected 5", bus.ap_return); end
    n_checks++;
    if (bus.firings_total !== 32'd9) begin n_fail++; $display("FAIL max2_total: got %0d expected 9", bus.firings_total); end
    tick();
  endtask

  task automatic test_write_stall;
    int lat, sw;
    logic [7:0] o0;
    push(32'd7);
    o0 = out_cnt;
    run_call(3, 5, lat, sw);
    n_checks++;
    if (sw !== 0) begin n_fail++; $display("FAIL stall_no_write: got %0d stalled writes expected 0", sw); end
    n_checks++;
    if (out_cnt - o0 !== 8'd1) begin n_fail++; $display("FAIL stall_single_write: got %0d expected 1", out_cnt - o0); end
    n_checks++;
    if (out_log[o0[4:0]] !== 32'd8) begin n_fail++; $display("FAIL stall_out: got %0d expected 8", out_log[o0[4:0]]); end
    n_checks++;
    if (lat !== 10) begin n_fail++; $display("FAIL stall_latency: got %0d expected 10", lat); end
    bus.out_full_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [5:0] done_vec;
    logic [5:0] idle_vec;
    bus.guard_en = 1'b0;
    done_vec = '0;
    idle_vec = '0;
    bus.ap_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 6) bus.ap_start = 1'b0;
      done_vec[c-1] = bus.ap_done;
      idle_vec[c-1] = bus.ap_idle;
    end
    n_checks++;
    if (done_vec !== 6'b010010) begin n_fail++; $display("FAIL b2b_done: got %b expected 010010", done_vec); end
    n_checks++;
    if (idle_vec !== 6'b100100) begin n_fail++; $display("FAIL b2b_idle: got %b expected 100100", idle_vec); end
    n_checks++;
    if (bus.ap_return !== 32'd4) begin n_fail++; $display("FAIL b2b_return: got %0d expected 4", bus.ap_return); end
    tick();
  endtask

  task automatic test_reset_in_compute;
    logic [7:0] o0;
    bus.guard_en = 1'b1;
    push(32'h55);
    o0 = out_cnt;
    bus.ap_start = 1'b1;
    tick();                 // CHECK: token read
    bus.ap_start = 1'b0;
    tick();                 // COMPUTE
    ap_rst = 1'b1;
    tick();                 // reset taken
    n_checks++;
    if (bus.ap_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b expected 1", bus.ap_idle); end
    n_checks++;
    if (bus.ap_return !== 32'd0) begin n_fail++; $display("FAIL rst_return: got %0d expected 0", bus.ap_return); end
    n_checks++;
    if (bus.out_write !== 1'b0 || bus.out_din !== 32'd0) begin
      n_fail++; $display("FAIL rst_out: got write=%b din=%0h expected write=0 din=0", bus.out_write, bus.out_din);
    end
    n_checks++;
    if (bus.firings_total !== 32'd0) begin n_fail++; $display("FAIL rst_total: got %0d expected 0", bus.firings_total); end
    ap_rst = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (out_cnt !== o0) begin n_fail++; $display("FAIL rst_token_dropped: got %0d writes expected 0", out_cnt - o0); end
    n_checks++;
    if (bus.ap_idle !== 1'b1) begin n_fail++; $display("FAIL rst_stays_idle: got %b expected 1", bus.ap_idle); end
  endtask

  initial begin
    ap_rst         = 1'b1;
    bus.ap_start   = 1'b0;
    bus.guard_en   = 1'b1;
    bus.out_full_n = 1'b1;
    test_reset();
    test_empty_input();
    test_guard_block();
    test_three_tokens();
    test_max_firings();
    test_write_stall();
    test_back_to_back();
    test_reset_in_compute();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/actor_responder.md
ACTOR_RESPONDER -- requirements
Module: actor_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: token width in bits, legal range 1..64.
REQ-002 Parameter INCREMENT, default 1: constant added to each consumed token.
REQ-003 Parameter COMPUTE_LATENCY, default 1: compute cycles per firing, legal range 1..255.
REQ-004 Parameter MAX_FIRINGS, default 4: firing limit per invocation, legal range 1..65535.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 ap_clk  in  1  clock; all state changes on its rising edge.
REQ-007 ap_rst  in  1  synchronous active-high reset.
REQ-008 ap_start  in  1  invocation request from the actor trigger.
REQ-009 ap_done  out  1  one-cycle pulse marking end of invocation.
REQ-010 ap_idle  out  1  high while no invocation is in progress.
REQ-011 ap_ready  out  1  one-cycle pulse, coincident with ap_done.
REQ-012 ap_return  out  32  return code: IDLE=0, WAIT_PREDICATE=1, WAIT_INPUT=2, WAIT_OUTPUT=3, WAIT_GAURD=4, EXECUTED=5.
REQ-013 guard_en  in  1  action guard; low blocks firing.
REQ-014 in_empty_n / in_read / in_dout  in / out / in  1 / 1 / DATA_WIDTH  first-word-fall-through input FIFO port.
REQ-015 out_full_n / out_write / out_din  in / out / out  1 / 1 / DATA_WIDTH  output FIFO port.
REQ-016 firings_total  out  32  count of completed firings since reset.

Function
REQ-017 FSM states: IDLE, CHECK, COMPUTE, WRITE, DONE.
REQ-018 IDLE: ap_idle=1; on ap_start=1, clear the per-call firing count and go to CHECK next cycle; ap_start is ignored in every other state.
REQ-019 CHECK evaluates conditions in this priority order, and the first one that holds is taken:
- per-call count == MAX_FIRINGS -> DONE;
- guard_en=0 -> record reason WAIT_GAURD, go to DONE;
- in_empty_n=0 -> record reason WAIT_INPUT, go to DONE;
- out_full_n=0 -> record reason WAIT_OUTPUT, go to DONE;
- otherwise -> assert in_read combinationally this cycle, latch in_dout, load the compute counter, go to COMPUTE.
REQ-020 in_read is asserted only in a CHECK cycle that passes every test of REQ-019, and never in any other cycle.
REQ-021 COMPUTE lasts exactly COMPUTE_LATENCY cycles, then goes to WRITE.
REQ-022 WRITE behaviour:
- out_din = (latched token + INCREMENT) mod 2^DATA_WIDTH;
- out_write = out_full_n;
- stay in WRITE until a write occurs;
- on the write: per-call count +1, firings_total +1 (wraps modulo 2^32), go to CHECK.
REQ-023 DONE lasts one cycle: ap_done=1, ap_ready=1, ap_return is registered as EXECUTED if per-call count > 0, else as the recorded reason; next state is IDLE.
REQ-024 ap_return holds its value from DONE until the next DONE or reset.
REQ-025 ap_idle=0 in every state other than IDLE.
REQ-026 Latency, with the start cycle being the IDLE cycle in which ap_start=1:
- blocked call: ap_done at start+2;
- each firing adds COMPUTE_LATENCY+2 cycles, plus any WRITE stall cycles.
REQ-027 With ap_start held high, a new invocation starts in the IDLE cycle that follows DONE.
REQ-028 No outputs depend combinationally on ap_start; in_read depends only on the state, the count, guard_en, in_empty_n and out_full_n.

Reset
REQ-029 ap_rst=1 on a clock edge forces:
- state IDLE;
- ap_idle=1;
- ap_done=0, ap_ready=0, in_read=0, out_write=0;
- ap_return=0 (IDLE);
- out_din=0, firings_total=0, all counters and latches cleared.
REQ-030 Reset during COMPUTE or WRITE discards the latched token; no out_write occurs in the cycle after reset.

Verification
REQ-031 Empty input, guard_en=1, out_full_n=1, pulse ap_start -> ap_done at start+2, ap_return=2, in_read never asserted.
REQ-032 guard_en=0, input holds 3 tokens, pulse ap_start -> ap_return=4, no in_read, firings_total=0.
REQ-033 Input tokens 10, 20, 0xFFFFFFFF with INCREMENT=1, output never full -> out_din 11, 21, 0 in order, ap_return=5, firings_total=3, ap_done at start+11 (COMPUTE_LATENCY=1).
REQ-034 Input holds 6 tokens, MAX_FIRINGS=4 -> 4 writes, ap_return=5, 2 tokens remain; a second ap_start -> 2 writes, then ap_return=5.
REQ-035 One token with out_full_n dropped low during WRITE for 5 cycles -> out_write stays 0 for 5 cycles, a single write follows, and ap_done is delayed by 5 cycles.
REQ-036 ap_rst asserted in COMPUTE -> next cycle ap_idle=1 and ap_return=0; that token is never written.
